// File: rtl/ctech_lib_clk_div_seq.sv
// ctech_lib_clk_div_seq
// Generates the D pattern for a downstream in/clk/clkout feedback flop, so
// that flop's clkout becomes clk divided by a programmable ratio. Ratio
// updates arrive on a 4-phase req/ack handshake. They take effect only at a
// period boundary, so clkout never glitches and never produces a runt pulse.
//
// Ports:
//   clk         source clock, shared with the downstream clock flop
//   rst_b       asynchronous active-low reset
//   div_en      1 = run, 0 = stop once the current period has completed
//   div_ratio   requested ratio, sampled on the div_req rising edge
//   div_req     4-phase ratio-change request
//   div_ack     4-phase acknowledge
//   ffb_in      registered pattern for the downstream flop `in` pin
//   div_active  1 while the sequencer is not idle
//   phase_cnt   position inside the current period (observability)
//   div_err     sticky illegal-ratio flag
//
// Build option: CTECH_CLK_DIV_ERR_EN
//   defined   -> a request with ratio < 2 is acked but not applied, and it
//                sets div_err
//   undefined -> a ratio < 2 is clamped to 2 and applied normally; div_err = 0
//
// state | meaning
// IDLE  | stopped, ffb_in held low
// RUN   | dividing with ratio_q
// PEND  | dividing, with a new ratio waiting for the next wrap edge

module ctech_lib_clk_div_seq #(
  parameter int CNT_W     = 6,
  parameter int RST_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             div_en,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             div_req,
  output logic             div_ack,
  output logic             ffb_in,
  output logic             div_active,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             div_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RST_RATIO_V = CNT_W'(RST_RATIO);
  localparam logic [CNT_W-1:0] MIN_RATIO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] ratio_q;
  logic [CNT_W-1:0] pend_q;
  logic             req_q;
  logic             ack_pend_q;

  logic             req_rise;
  logic             ratio_bad;
  logic [CNT_W-1:0] req_ratio;
  logic             at_wrap;
  logic [CNT_W-1:0] phase_inc;
  logic [CNT_W-1:0] high_len;
  logic             err_set;

  // A new request is accepted only when the previous handshake has fully
  // closed: no ack is outstanding or scheduled, and no ratio is pending.
  assign req_rise  = div_req & ~req_q & ~div_ack & ~ack_pend_q & (state != PEND);
  assign ratio_bad = (div_ratio < MIN_RATIO);
  assign req_ratio = ratio_bad ? MIN_RATIO : div_ratio;
  assign at_wrap   = (phase_cnt == ratio_q - ONE);
  assign phase_inc = phase_cnt + ONE;
  // ceil(N/2), computed without the overflow that N+1 would hit at the
  // maximum ratio
  assign high_len  = (ratio_q >> 1) + {{(CNT_W-1){1'b0}}, ratio_q[0]};

`ifdef CTECH_CLK_DIV_ERR_EN
  logic err_q;

  assign err_set = req_rise & ratio_bad;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign div_err = err_q;
`else
  assign err_set = 1'b0;
  assign div_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      ratio_q    <= RST_RATIO_V;
      pend_q     <= '0;
      req_q      <= 1'b0;
      ack_pend_q <= 1'b0;
      div_ack    <= 1'b0;
      ffb_in     <= 1'b0;
      div_active <= 1'b0;
      phase_cnt  <= '0;
    end else begin
      req_q      <= div_req;
      ack_pend_q <= 1'b0;
      if (ack_pend_q) begin
        div_ack <= 1'b1;
      end else if (!div_req) begin
        div_ack <= 1'b0;
      end

      case (state)
        IDLE: begin
          phase_cnt <= '0;
          ffb_in    <= 1'b0;
          if (req_rise) begin
            if (!err_set) begin
              ratio_q <= req_ratio;
            end
            ack_pend_q <= 1'b1;
          end
          if (div_en) begin
            state      <= RUN;
            div_active <= 1'b1;
            ffb_in     <= 1'b1;
          end
        end

        default: begin
          if (at_wrap) begin
            phase_cnt <= '0;
            if (state == PEND) begin
              ratio_q <= pend_q;
              div_ack <= 1'b1;
            end
            // div_en is only honoured here, so a 1->0->1 blip mid-period is
            // harmless and a stop never truncates a period
            if (div_en) begin
              state  <= RUN;
              ffb_in <= 1'b1;
            end else begin
              state      <= IDLE;
              ffb_in     <= 1'b0;
              div_active <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_inc;
            ffb_in    <= (phase_inc < high_len);
          end

          // Only reachable from RUN (PEND blocks req_rise).
          if (req_rise) begin
            if (err_set) begin
              ack_pend_q <= 1'b1;
            end else if (at_wrap && !div_en) begin
              // stopping on this edge: behave as an idle request
              ratio_q    <= req_ratio;
              ack_pend_q <= 1'b1;
            end else begin
              pend_q <= req_ratio;
              state  <= PEND;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ctech_lib_clk_div_seq.md
Name: ctech_lib_clk_div_seq

Overview:
- Sequencer that generates the D-input pattern for a downstream clock feedback flop (in/clk/clkout cell). Its registered output drives the flop's `in` pin, so that flop's clkout is a divided clock.
- Division ratio is programmable. Ratio changes use a 4-phase req/ack handshake and are applied only at period boundaries, so clkout never glitches or produces a runt pulse.
- Sits in the local clock-generation cluster, clocked by the same clk as the downstream flop.

Parameters:
- CNT_W, 6, width of ratio and phase counter; legal ratios 2..2^CNT_W-1.
- RST_RATIO, 2, ratio loaded at reset; must be >=2.

Ports:
- clk  input  1  source clock, shared with the downstream clock flop.
- rst_b  input  1  asynchronous active-low reset.
- div_en  input  1  level; 1 = run the divider, 0 = stop at the end of the current period.
- div_ratio  input  CNT_W  requested ratio N; sampled only on div_req rise.
- div_req  input  1  4-phase ratio-change request.
- div_ack  output  1  4-phase acknowledge.
- ffb_in  output  1  registered pattern; drives the downstream flop `in`.
- div_active  output  1  1 when state != IDLE.
- phase_cnt  output  CNT_W  current phase counter, for observability.
- div_err  output  1  sticky illegal-ratio flag; tied 0 when CTECH_CLK_DIV_ERR_EN is undefined.

Behaviour:
- Reset is asynchronous, active-low (rst_b). Outputs/state go to reset values immediately, including mid-period or mid-handshake.
  - state=IDLE, ratio_q=RST_RATIO, pend_q=0.
  - phase_cnt=0, ffb_in=0, div_ack=0, div_err=0.
- All outputs are flops; no combinational path from inputs to outputs.
- High-phase length: H=(ratio_q+1)>>1 (odd N: H high cycles, N-H low cycles).
- States: IDLE, RUN, PEND.
- IDLE:
  - ffb_in=0, phase_cnt=0.
  - div_en=1 sampled -> next edge: RUN, phase_cnt=0, ffb_in=1.
- RUN, each edge:
  - phase_cnt <= (phase_cnt==ratio_q-1) ? 0 : phase_cnt+1.
  - ffb_in <= (next phase_cnt < H).
  - ffb_in period is exactly ratio_q cycles.
- Wrap edge: the edge where phase_cnt==ratio_q-1.
- Ratio request:
  - Detected on the rising edge of div_req (registered req_q edge detect).
  - In IDLE: ratio_q<=div_ratio at the detect edge; div_ack=1 on the following edge.
  - In RUN: pend_q<=div_ratio, state -> PEND.
  - PEND counts as RUN. At the wrap edge: ratio_q<=pend_q, phase_cnt<=0, ffb_in<=1, div_ack<=1, state -> RUN.
- div_ack:
  - Held 1 while div_req=1; drops one edge after div_req is sampled 0.
  - A new div_req rise is ignored until div_ack=0.
- Stop:
  - div_en=0 sampled in RUN/PEND: finish the current period.
  - At the wrap edge: state -> IDLE, ffb_in<=0, phase_cnt<=0.
  - If PEND, the pending ratio is applied and acked at that same wrap edge.
- div_en toggling 1->0->1 before the wrap edge: no stop, the period continues.
- div_ratio changes while no request is pending: ignored.
- Ratio change never shortens or extends a period already in progress.

Optional Feature:
- Macro CTECH_CLK_DIV_ERR_EN.
- Defined:
  - A request with div_ratio<2 leaves ratio_q unchanged.
  - The handshake still completes: div_ack on the next edge, no PEND.
  - div_err sets and stays 1 until reset.
- Undefined:
  - div_ratio<2 is clamped to 2 and applied normally (PEND/wrap rules).
  - div_err is constant 0.

Test Plan:
- Reset, div_en=1, no request -> ffb_in=1 one edge after div_en sampled, then 1,0 repeating (period 2); div_active=1.
- In IDLE, req ratio=5, then div_en=1 -> ffb_in pattern 1,1,1,0,0 repeating; ack rises 1 edge after req detect, falls 1 edge after req low.
- Running N=4, req ratio=3 at phase_cnt=1 -> phases 2,3 complete unchanged; at wrap, pattern becomes 1,1,0; ack coincides with the first high of the new period.
- Running N=6, div_en=0 at phase_cnt=2 -> ffb_in completes 0,0,0 through phase_cnt=5, then stays 0; div_active=0 after the wrap; no short pulse.
- Running N=7, assert rst_b=0 mid-high-phase -> ffb_in, div_ack, phase_cnt go to 0 immediately; after release, ratio_q=2.
- Req ratio=1: with CTECH_CLK_DIV_ERR_EN, div_err=1 and ratio unchanged; without it, ratio becomes 2 at the next wrap.
